dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter for the single-port data-memory block RAM. Port 0 is the CPU load/store path. Port 1 is the UART program/data loader. The block picks one request per cycle, drives the RAM port, and routes read data back to the winning requester one cycle later. It sits between the memory/IO address-decode stage and the data-memory RAM instance, and runs in the CPU clock domain.

## Interface

Parameters:
- ADDR_W, 14, word-address width of the RAM.
- DATA_W, 32, data width.

Ports:
- clk  in  1  CPU clock. The block has one clock; all logic is on its rising edge.
- rstn  in  1  Asynchronous, active-low reset.
- boot_mode  in  1  1 = port 1 has strict priority; 0 = round-robin between the ports.
- m0_req  in  1  CPU access request.
- m0_we  in  1  CPU write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  CPU word address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_gnt  out  1  CPU request accepted this cycle.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_W  CPU read data.
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/ADDR_W/DATA_W  Loader request, same meaning as the m0 inputs.
- m1_gnt, m1_rvalid, m1_rdata  out  1/1/DATA_W  Loader outputs, same meaning as the m0 outputs.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data. It is valid in the cycle after ram_en with ram_we=0.
- conflict_cnt  out  16  Count of cycles in which both ports requested. Saturates at 16'hFFFF.

## Operation

Request rules:
- A requester raises mX_req with we/addr/wdata valid.
- It must hold req, we, addr and wdata stable until mX_gnt=1.
- A request is accepted in the cycle where req and gnt are both 1.
- At most one grant is issued per cycle.

Grant selection (combinational from the req inputs and the registered state):
- If only one port requests, that port wins.
- If both request and boot_mode=1, port 1 wins.
- If both request and boot_mode=0, the port that was not last granted wins.

RAM port drive:
- In a grant cycle: ram_en=1, and ram_we, ram_addr and ram_wdata equal the winner's inputs.
- Otherwise: ram_en=0, ram_we=0, and ram_addr/ram_wdata=0.

Registered state:
- last_gnt (1 bit): updated to the winner on every grant. It is updated on grants in boot_mode as well.
- rd_owner_v (1 bit) and rd_owner (1 bit): set on a read grant; cleared on a cycle with no read grant.
- conflict_cnt (16 bit).

Read return:
- One cycle after a read grant to port X, mX_rvalid=1 and mX_rdata=ram_rdata.
- The other port's rvalid is 0 and its rdata holds its last value.
- Back-to-back reads are fully pipelined, one per cycle, and may alternate ports.

Writes:
- A write produces no rvalid.

conflict_cnt:
- Increments in every cycle with m0_req & m1_req.
- Holds at 16'hFFFF.

Simultaneous events:
- A grant to one port and an rvalid to the other port in the same cycle is legal and expected.
- A read-after-write to the same address on consecutive cycles returns the new data; the RAM is write-first.

Reset:
- The following are 0 while rstn=0, asynchronously: gnt outputs, rvalid outputs, rdata outputs, ram_en, ram_we, ram_addr, ram_wdata and conflict_cnt.
- last_gnt resets to 1, so port 0 wins the first tie.
- A read granted in the cycle before reset asserts is dropped; no rvalid appears after reset releases.

## Timing

- Grant latency: 0 cycles. gnt is combinational in the request cycle if the port wins.
- Read latency: 1 cycle from the accepted request to rvalid.
- Worst-case wait for port 0 in round-robin with port 1 saturating: 1 cycle.
- In boot_mode, port 0 can starve indefinitely. The loader is required to stall the CPU for the duration of programming.
- There are no combinational paths from ram_rdata to any gnt output.

## Test plan

- After reset, m0 reads addr 0x010 alone → m0_gnt=1 in cycle 0, ram_en=1, ram_we=0, ram_addr=0x010; in cycle 1, m0_rvalid=1, m0_rdata equals the RAM content, m1_rvalid=0.
- boot_mode=0, both ports hold read requests for 4 cycles → grants go m0,m1,m0,m1; rvalids follow one cycle later in the same order; conflict_cnt=4.
- boot_mode=1, both ports request for 3 cycles → m1_gnt=1 on all 3 cycles, m0_gnt=0; conflict_cnt=3.
- m1 writes 0xDEADBEEF to 0x020, then m0 reads 0x020 on the next cycle → m0_rdata=0xDEADBEEF one cycle after the m0 grant.
- rstn pulses low for 1 cycle in the cycle right after an m0 read grant → m0_rvalid stays 0; all outputs are 0; on the next tie, m0 wins.
- Force both req high for 70000 cycles → conflict_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data-memory RAM.
// Port 0 is the CPU path and port 1 is the UART loader; read data returns one cycle after the grant.
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              boot_mode,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       conflict_cnt
);

  logic              last_gnt_reg;
  logic              rd_owner_v_reg;
  logic              rd_owner_reg;
  logic [15:0]       conflict_cnt_reg;

  logic              both_req;
  logic              pick1;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [1:0]        rvalid_w;
  logic [DATA_W-1:0] rdata_w [2];

  // On a tie, boot mode forces the loader; otherwise the port not granted last wins.
  assign both_req  = m0_req & m1_req;
  assign pick1     = both_req ? (boot_mode | ~last_gnt_reg) : m1_req;
  assign grant     = rstn & (m0_req | m1_req);

  assign m0_gnt    = grant & ~pick1;
  assign m1_gnt    = grant & pick1;

  assign sel_we    = pick1 ? m1_we    : m0_we;
  assign sel_addr  = pick1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick1 ? m1_wdata : m0_wdata;

  assign ram_en    = grant;
  assign ram_we    = grant & sel_we;
  assign ram_addr  = grant ? sel_addr  : '0;
  assign ram_wdata = grant ? sel_wdata : '0;

  assign conflict_cnt = conflict_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt_reg     <= 1'b1;
      rd_owner_v_reg   <= 1'b0;
      rd_owner_reg     <= 1'b0;
      conflict_cnt_reg <= '0;
    end else begin
      if (grant) begin
        last_gnt_reg <= pick1;
      end
      rd_owner_v_reg <= grant & ~sel_we;
      if (grant & ~sel_we) begin
        rd_owner_reg <= pick1;
      end
      if (both_req && conflict_cnt_reg != 16'hFFFF) begin
        conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
    end
  end

  // Read return: live RAM data in the valid cycle, otherwise the last value captured.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic [DATA_W-1:0] hold_reg;

      assign rvalid_w[gi] = rd_owner_v_reg & (rd_owner_reg == 1'(gi));
      assign rdata_w[gi]  = rvalid_w[gi] ? ram_rdata : hold_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          hold_reg <= '0;
        end else if (rvalid_w[gi]) begin
          hold_reg <= ram_rdata;
        end
      end
    end
  endgenerate

  assign m0_rvalid = rvalid_w[0];
  assign m1_rvalid = rvalid_w[1];
  assign m0_rdata  = rdata_w[0];
  assign m1_rdata  = rdata_w[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first registered-read RAM model.
// Inputs change 1 time unit after the rising edge and outputs are checked 1 unit later.
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rstn;
  logic              boot_mode;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [15:0]       conflict_cnt;

  int total;
  int bad;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .boot_mode(boot_mode),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each word starts out as 0xA500_0000 | address.
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | 32'(i);
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    boot_mode = 1'b0;
    drive(1'b1, 1'b0, 14'h010, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);

    // Reset holds every output low even with a request pending.
    #3;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'h0);
    tick;
    tick;
    rstn = 1'b1;

    // Lone m0 read of 0x010.
    $display("txn: m0 read 0x010");
    #1;
    chk("t1_m0_gnt", 32'(m0_gnt), 32'h1);
    chk("t1_m1_gnt", 32'(m1_gnt), 32'h0);
    chk("t1_ram_en", 32'(ram_en), 32'h1);
    chk("t1_ram_we", 32'(ram_we), 32'h0);
    chk("t1_ram_addr", 32'(ram_addr), 32'h010);
    tick;
    drive(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("t1_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("t1_m0_rdata", m0_rdata, 32'hA500_0010);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("t1_idle_ram_en", 32'(ram_en), 32'h0);

    // Fresh reset so the first tie goes to m0.
    rstn = 1'b0;
    #1;
    rstn = 1'b1;

    // Round-robin: both read for 4 cycles -> m0, m1, m0, m1.
    drive(1'b1, 1'b0, 14'h001, 32'h0, 1'b1, 1'b0, 14'h002, 32'h0);
    for (int k = 0; k < 4; k++) begin
      $display("txn: rr tie cycle %0d", k);
      #1;
      chk($sformatf("rr%0d_m0_gnt", k), 32'(m0_gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d_m1_gnt", k), 32'(m1_gnt), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k == 1) begin
        chk("rr1_m0_rvalid", 32'(m0_rvalid), 32'h1);
        chk("rr1_m0_rdata", m0_rdata, 32'hA500_0001);
      end
      if (k == 2) begin
        chk("rr2_m1_rvalid", 32'(m1_rvalid), 32'h1);
        chk("rr2_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rr2_m1_rdata", m1_rdata, 32'hA500_0002);
        chk("rr2_m0_rdata_hold", m0_rdata, 32'hA500_0001);
      end
      tick;
    end
    drive(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("rr_tail_m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("rr_tail_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rr_cnt", 32'(conflict_cnt), 32'd4);

    // Boot mode: loader wins every tie.
    boot_mode = 1'b1;
    drive(1'b1, 1'b0, 14'h003, 32'h0, 1'b1, 1'b0, 14'h004, 32'h0);
    for (int k = 0; k < 3; k++) begin
      $display("txn: boot tie cycle %0d", k);
      #1;
      chk($sformatf("boot%0d_m1_gnt", k), 32'(m1_gnt), 32'h1);
      chk($sformatf("boot%0d_m0_gnt", k), 32'(m0_gnt), 32'h0);
      tick;
    end
    boot_mode = 1'b0;
    drive(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("boot_cnt", 32'(conflict_cnt), 32'd7);
    chk("boot_m1_rdata", m1_rdata, 32'hA500_0004);
    tick;

    // m1 writes 0x020, then m0 reads it back.
    $display("txn: m1 write 0x020");
    drive(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, 14'h020, 32'hDEAD_BEEF);
    #1;
    chk("wr_m1_gnt", 32'(m1_gnt), 32'h1);
    chk("wr_ram_we", 32'(ram_we), 32'h1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h020);
    chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick;
    $display("txn: m0 read 0x020");
    drive(1'b1, 1'b0, 14'h020, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("raw_m0_gnt", 32'(m0_gnt), 32'h1);
    chk("raw_m1_rvalid", 32'(m1_rvalid), 32'h0);
    tick;
    drive(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("raw_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("raw_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    tick;

    // Reset right after an m0 read grant drops the read.
    $display("txn: m0 read 0x030 then reset");
    drive(1'b1, 1'b0, 14'h030, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("rd_rst_m0_gnt", 32'(m0_gnt), 32'h1);
    tick;
    rstn = 1'b0;
    #1;
    chk("in_rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("in_rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("in_rst_ram_en", 32'(ram_en), 32'h0);
    chk("in_rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("in_rst_m0_rdata", m0_rdata, 32'h0);
    chk("in_rst_cnt", 32'(conflict_cnt), 32'h0);
    tick;
    rstn = 1'b1;
    drive(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("post_rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    tick;
    $display("txn: tie after reset");
    drive(1'b1, 1'b0, 14'h005, 32'h0, 1'b1, 1'b0, 14'h006, 32'h0);
    #1;
    chk("post_rst_tie_m0_gnt", 32'(m0_gnt), 32'h1);
    chk("post_rst_tie_m1_gnt", 32'(m1_gnt), 32'h0);

    // Saturation: 70000 tie cycles.
    $display("txn: 70000 tie cycles");
    repeat (70000) tick;
    #1;
    chk("sat_cnt", 32'(conflict_cnt), 32'hFFFF);
    tick;
    #1;
    chk("sat_hold_cnt", 32'(conflict_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
